// File: rtl/tdc_multistop.sv
// Multi-stop time-to-digital converter: one start edge, up to MAX_STOPS timestamped stops,
// records queued in a first-word-fall-through FIFO with valid/ready readout.
module tdc_multistop #(
  parameter int unsigned COARSE_W   = 28,
  parameter int unsigned FINE_W     = 6,
  parameter int unsigned MAX_STOPS  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(MAX_STOPS),
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned REC_W = 1 + IDX_W + COARSE_W + 2 * FINE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signal,
  input  logic [FINE_W-1:0]   fine_code,
  input  logic                arm,
  input  logic                abort,
  input  logic                continuous,
  input  logic [IDX_W:0]      n_stops,
  input  logic [COARSE_W-1:0] timeout,
  output logic [REC_W-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow,
  input  logic                clear_ovf,
  output logic                meas_done,
  output logic [1:0]          state_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MEAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic                signal_d;
  logic [COARSE_W-1:0] cnt;
  logic [COARSE_W-1:0] tmo_lat;
  logic [IDX_W-1:0]    stop_idx;
  logic [IDX_W:0]      n_lat;
  logic [FINE_W-1:0]   fine_start;

  logic                rise;
  logic                last_stop;
  logic                tmo_hit;
  logic [IDX_W:0]      n_clamped;
  logic                push;
  logic [REC_W-1:0]    push_rec;

  assign rise      = signal & ~signal_d;
  assign last_stop = ((IDX_W+1)'(stop_idx) + (IDX_W+1)'(1)) == n_lat;
  assign tmo_hit   = (tmo_lat != '0) && (cnt == tmo_lat);
  assign state_out = state;

  // Stop count request clamped into 1..MAX_STOPS
  always_comb begin
    n_clamped = n_stops;
    if (n_stops == '0)
      n_clamped = (IDX_W+1)'(1);
    else if (n_stops > (IDX_W+1)'(MAX_STOPS))
      n_clamped = (IDX_W+1)'(MAX_STOPS);
  end

  // Record to queue this cycle; a stop edge beats a coincident timeout, abort suppresses both
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    if (state == MEAS && !abort) begin
      if (rise) begin
        push     = 1'b1;
        push_rec = {1'b0, stop_idx, cnt, fine_start, fine_code};
      end else if (tmo_hit) begin
        push     = 1'b1;
        push_rec = {1'b1, stop_idx, cnt, fine_start, FINE_W'(0)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      signal_d   <= 1'b1;
      cnt        <= '0;
      tmo_lat    <= '0;
      stop_idx   <= '0;
      n_lat      <= '0;
      fine_start <= '0;
      meas_done  <= 1'b0;
    end else begin
      signal_d  <= signal;
      meas_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (arm) state <= ARMED;
          ARMED: begin
            if (rise) begin
              state      <= MEAS;
              fine_start <= fine_code;
              n_lat      <= n_clamped;
              tmo_lat    <= timeout;
              cnt        <= COARSE_W'(1);
              stop_idx   <= '0;
            end
          end
          MEAS: begin
            if (cnt != '1) cnt <= cnt + COARSE_W'(1);
            if (rise) begin
              stop_idx <= stop_idx + IDX_W'(1);
              if (last_stop) begin
                state     <= DONE;
                meas_done <= 1'b1;
              end
            end else if (tmo_hit) begin
              state     <= DONE;
              meas_done <= 1'b1;
            end
          end
          DONE: state <= continuous ? ARMED : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output FIFO: a push into a full FIFO survives only if a pop frees a slot the same cycle
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             accept;

  assign full   = count == CNT_W'(FIFO_DEPTH);
  assign pop    = (count != '0) && m_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  assign m_data     = mem[rd_ptr];
  assign m_valid    = count != '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_tdc_multistop.sv
// Bench for tdc_multistop: expected records derived from stop/timeout offsets go into a
// scoreboard queue; an independent monitor pops and compares every record the DUT hands out.
module tb_tdc_multistop;

  localparam int unsigned COARSE_W   = 28;
  localparam int unsigned FINE_W     = 6;
  localparam int unsigned MAX_STOPS  = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned IDX_W = $clog2(MAX_STOPS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned REC_W = 1 + IDX_W + COARSE_W + 2 * FINE_W;

  logic                clk;
  logic                rst;
  logic                signal;
  logic [FINE_W-1:0]   fine_code;
  logic                arm;
  logic                abort;
  logic                continuous;
  logic [IDX_W:0]      n_stops;
  logic [COARSE_W-1:0] timeout;
  logic [REC_W-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;
  logic [CNT_W-1:0]    fifo_count;
  logic                overflow;
  logic                clear_ovf;
  logic                meas_done;
  logic [1:0]          state_out;

  tdc_multistop #(
    .COARSE_W(COARSE_W), .FINE_W(FINE_W), .MAX_STOPS(MAX_STOPS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .fine_code(fine_code), .arm(arm),
    .abort(abort), .continuous(continuous), .n_stops(n_stops), .timeout(timeout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
    .overflow(overflow), .clear_ovf(clear_ovf), .meas_done(meas_done), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 1;   // 0: hold off, 1: always ready, 2: random
  bit ovf_exp = 1'b0;
  int offs[16];
  int fines[16];
  int n_offs = 0;
  int fs = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [REC_W-1:0] make_rec(input bit t, input int idx, input int coarse,
                                                input int f0, input int f1);
    return {t, IDX_W'(idx), COARSE_W'(coarse), FINE_W'(f0), FINE_W'(f1)};
  endfunction

  function automatic void exp_push(input logic [REC_W-1:0] r);
    if (exp_q.size() < int'(FIFO_DEPTH)) exp_q.push_back(r);
    else ovf_exp = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer ready generator
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
    end
  end

  // Monitor: every handshake pops one expected record
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got 0x%0h, expected no record", m_data);
        end else begin
          chk("record", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drain();
    ready_mode = 2;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || m_valid); i++) tick();
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
    chk("drain_valid_low", 64'(m_valid), 0);
  endtask

  // Start edge, then stops at offs[] cycles after the start-detect cycle
  task automatic run_meas(input int n_raw, input int tmo, input bit do_arm, input bit cont,
                          input int abort_at, input int rst_at);
    int n;
    int end_c;
    int np;
    bit live;
    bit stopped;
    n = (n_raw == 0) ? 1 : (n_raw > int'(MAX_STOPS)) ? int'(MAX_STOPS) : n_raw;
    end_c = -1;
    np = 0;
    live = (tmo != 0);
    stopped = 1'b0;
    for (int i = 0; i < n_offs && end_c < 0 && !stopped; i++) begin
      int o;
      o = offs[i];
      if ((abort_at != 0 && abort_at <= o) || (rst_at != 0 && rst_at <= o)) begin
        stopped = 1'b1;
      end else if (live && tmo < o) begin
        exp_push(make_rec(1'b1, np, tmo, fs, 0));
        end_c = tmo;
      end else begin
        exp_push(make_rec(1'b0, np, o, fs, fines[i]));
        np++;
        if (o == tmo) live = 1'b0;
        if (np == n) end_c = o;
      end
    end
    if (end_c < 0 && !stopped && live) begin
      exp_push(make_rec(1'b1, np, tmo, fs, 0));
      end_c = tmo;
    end

    n_stops    = (IDX_W+1)'(n_raw);
    timeout    = COARSE_W'(tmo);
    continuous = cont;
    if (do_arm) begin
      chk("idle_before_arm", 64'(state_out), 0);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("armed", 64'(state_out), 1);
    end else begin
      chk("rearmed", 64'(state_out), 1);
    end
    signal    = 1'b1;
    fine_code = FINE_W'(fs);
    tick();
    signal = 1'b0;
    chk("measuring", 64'(state_out), 2);
    for (int c = 1; c <= 400; c++) begin
      int k;
      k = -1;
      for (int j = 0; j < n_offs; j++) if (offs[j] == c) k = j;
      signal    = (k >= 0);
      fine_code = (k >= 0) ? FINE_W'(fines[k]) : FINE_W'($urandom_range(0, 63));
      abort     = (c == abort_at);
      if (c == rst_at) begin
        chk("fifo_before_rst", 64'(fifo_count), 64'(exp_q.size()));
        rst = 1'b1;
      end
      tick();
      signal = 1'b0;
      abort  = 1'b0;
      if (c == rst_at) begin
        rst = 1'b0;
        exp_q.delete();
        chk("rst_state", 64'(state_out), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_data", 64'(m_data), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_done", 64'(meas_done), 0);
        return;
      end
      if (c == abort_at) begin
        chk("abort_idle", 64'(state_out), 0);
        return;
      end
      if (c == end_c) begin
        chk("done_state", 64'(state_out), 3);
        chk("done_pulse", 64'(meas_done), 1);
        tick();
        chk("after_done_state", 64'(state_out), cont ? 64'd1 : 64'd0);
        chk("done_pulse_end", 64'(meas_done), 0);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL meas_end: got no end within 400 cycles, expected end at %0d", end_c);
  endtask

  task automatic rand_fines();
    fs = $urandom_range(0, 63);
    for (int i = 0; i < 16; i++) fines[i] = $urandom_range(0, 63);
  endtask

  initial begin
    rst = 1'b1; signal = 1'b0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    n_stops = '0; timeout = '0; fine_code = '0; clear_ovf = 1'b0;
    tick(); tick();
    chk("reset_state", 64'(state_out), 0);
    chk("reset_valid", 64'(m_valid), 0);
    chk("reset_count", 64'(fifo_count), 0);
    chk("reset_ovf", 64'(overflow), 0);
    chk("reset_done", 64'(meas_done), 0);
    chk("reset_data", 64'(m_data), 0);
    rst = 1'b0;
    tick();

    // Single stop, exact record {0,0,10,5,9}
    n_offs = 1; offs[0] = 10; fs = 5; fines[0] = 9;
    run_meas(1, 0, 1'b1, 1'b0, 0, 0);
    drain();

    // Three stops
    rand_fines();
    n_offs = 3; offs[0] = 4; offs[1] = 7; offs[2] = 20;
    run_meas(3, 0, 1'b1, 1'b0, 0, 0);
    drain();

    // Timeout after one of two stops
    rand_fines();
    n_offs = 1; offs[0] = 8;
    run_meas(2, 50, 1'b1, 1'b0, 0, 0);
    drain();

    // Stop coincident with timeout wins
    rand_fines();
    n_offs = 2; offs[0] = 10; offs[1] = 14;
    run_meas(2, 10, 1'b1, 1'b0, 0, 0);
    drain();

    // Clamping of n_stops: 0 -> 1, 7 -> MAX_STOPS
    rand_fines();
    n_offs = 2; offs[0] = 3; offs[1] = 6;
    run_meas(0, 0, 1'b1, 1'b0, 0, 0);
    drain();
    rand_fines();
    n_offs = 5; offs[0] = 3; offs[1] = 6; offs[2] = 9; offs[3] = 12; offs[4] = 15;
    run_meas(7, 0, 1'b1, 1'b0, 0, 0);
    drain();

    // Continuous re-arm, then abort out of ARMED
    for (int i = 0; i < 3; i++) begin
      rand_fines();
      n_offs = 1; offs[0] = $urandom_range(2, 12);
      run_meas(1, 0, (i == 0), 1'b1, 0, 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_from_armed", 64'(state_out), 0);
    drain();

    // Overflow: consumer stalled, FIFO_DEPTH+2 records
    ready_mode = 0;
    tick(); tick();
    ovf_exp = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH) + 2; i++) begin
      rand_fines();
      n_offs = 1; offs[0] = $urandom_range(2, 10);
      run_meas(1, 0, (i == 0), (i != int'(FIFO_DEPTH) + 1), 0, 0);
    end
    chk("full_count", 64'(fifo_count), 64'(FIFO_DEPTH));
    chk("overflow_set", 64'(overflow), 64'(ovf_exp));
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("overflow_cleared", 64'(overflow), 0);
    drain();

    // Abort on a stop edge: earlier stop kept, no push for the aborted edge
    rand_fines();
    n_offs = 3; offs[0] = 6; offs[1] = 15; offs[2] = 22;
    run_meas(3, 0, 1'b1, 1'b0, 15, 0);
    drain();

    // Reset mid-measurement with a record waiting
    ready_mode = 0;
    tick(); tick();
    rand_fines();
    n_offs = 2; offs[0] = 5; offs[1] = 30;
    run_meas(2, 0, 1'b1, 1'b0, 0, 12);
    drain();

    // Randomized single-shot measurements
    for (int it = 0; it < 20; it++) begin
      int n_raw;
      int n;
      int tmo;
      int cur;
      rand_fines();
      n_raw = $urandom_range(0, 7);
      n = (n_raw == 0) ? 1 : (n_raw > int'(MAX_STOPS)) ? int'(MAX_STOPS) : n_raw;
      tmo = ($urandom_range(0, 1) == 1) ? 2 * $urandom_range(1, 30) + 1 : 0;
      n_offs = (tmo != 0) ? $urandom_range(0, n) : n;
      cur = 0;
      for (int i = 0; i < n_offs; i++) begin
        cur += 2 * $urandom_range(1, 6);
        offs[i] = cur;
      end
      run_meas(n_raw, tmo, 1'b1, 1'b0, 0, 0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
